// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding, block geometry and address-split widths for the instruction cache
package icache_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2} state_t;
   localparam int BLOCK_W = 128;
   localparam int WORD_W = 32;
   localparam int OFFSET_LSB = 2;
   localparam int INDEX_LSB = 4;
   function automatic int index_width(input int num_blocks);
      return $clog2(num_blocks);
   endfunction
   function automatic int tag_width(input int addr_w, input int num_blocks);
      return addr_w - INDEX_LSB - $clog2(num_blocks);
   endfunction
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with async clear, combinational read, one sync write port
// ports: clk, rst_n (async active-low clear); rd_index/rd_offset -> rd_valid, rd_tag, rd_word;
//        we with wr_index/wr_tag/wr_data writes a whole line and marks it valid
module icache_line_array
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int TAG_W = 3,
   parameter int WORDS_PER_BLOCK = 4,
   localparam int IW = index_width(NUM_BLOCKS),
   localparam int OW = $clog2(WORDS_PER_BLOCK)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IW-1:0]      rd_index,
   input  logic [OW-1:0]      rd_offset,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [WORD_W-1:0]  rd_word,
   input  logic               we,
   input  logic [IW-1:0]      wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_data
);
   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]      tags [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data [NUM_BLOCKS];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            tags[i] <= '0;
            data[i] <= '0;
         end
      end else if (we) begin
         valid[wr_index] <= 1'b1;
         tags[wr_index]  <= wr_tag;
         data[wr_index]  <= wr_data;
      end
   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_word  = data[rd_index][WORD_W*rd_offset +: WORD_W];
endmodule

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped read-only instruction cache with block refill FSM
// ports: CLK, RESET (async active-low); pc -> instruction, busywait (cpu stall);
//        mem_read/mem_address request a block, mem_readdata/mem_busywait return it
module icache_controller
   import icache_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int NUM_BLOCKS = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        pc,
   output logic [31:0]        instruction,
   output logic               busywait,
   output logic               mem_read,
   output logic [ADDR_W-5:0]  mem_address,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);
   localparam int IW = index_width(NUM_BLOCKS);
   localparam int TW = tag_width(ADDR_W, NUM_BLOCKS);
   localparam int OW = $clog2(WORDS_PER_BLOCK);
   state_t               state, next;
   logic [IW-1:0]        index, miss_index;
   logic [TW-1:0]        tag, miss_tag, line_tag;
   logic [OW-1:0]        offset;
   logic [BLOCK_W-1:0]   fill_buf;
   logic                 line_valid, hit, unused_pc;
   assign offset    = pc[OFFSET_LSB +: OW];
   assign index     = pc[INDEX_LSB +: IW];
   assign tag       = pc[INDEX_LSB+IW +: TW];
   // byte-lane bits and bits above the memory address range never take part in lookup
   assign unused_pc = ^{pc[31:ADDR_W], pc[OFFSET_LSB-1:0]};
   icache_line_array #(
      .NUM_BLOCKS(NUM_BLOCKS), .TAG_W(TW), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
   ) u_lines (
      .clk(CLK), .rst_n(RESET),
      .rd_index(index), .rd_offset(offset),
      .rd_valid(line_valid), .rd_tag(line_tag), .rd_word(instruction),
      .we(state == UPDATE), .wr_index(miss_index), .wr_tag(miss_tag), .wr_data(fill_buf)
   );
   assign hit = line_valid & (line_tag == tag);
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         state      <= IDLE;
         miss_tag   <= '0;
         miss_index <= '0;
         fill_buf   <= '0;
      end else begin
         state <= next;
         if (state == IDLE && !hit) begin
            miss_tag   <= tag;
            miss_index <= index;
         end
         if (state == MEM_READ && !mem_busywait) fill_buf <= mem_readdata;
      end
   always_comb begin
      next        = state == IDLE ? (hit ? IDLE : MEM_READ) :
                    state == MEM_READ ? (mem_busywait ? MEM_READ : UPDATE) : IDLE;
      mem_read    = state == MEM_READ;
      mem_address = {miss_tag, miss_index};
      busywait    = (state != IDLE) | ~hit;
   end
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: randomized fetch traffic against a transaction-level cache and memory model
module tb_icache_controller;
   logic         CLK, RESET;
   logic [31:0]  pc, instruction;
   logic         busywait, mem_read, mem_busywait;
   logic [5:0]   mem_address;
   logic [127:0] mem_readdata, junk;
   logic [127:0] mem [64];
   int           lat, cnt, checks, errors;
   bit           vm [8];
   logic [2:0]   tm [8];

   icache_controller dut (
      .CLK(CLK), .RESET(RESET), .pc(pc), .instruction(instruction), .busywait(busywait),
      .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   // memory: busy from the first request cycle, data valid only in the last of lat cycles
   always @(posedge CLK) begin
      cnt  <= mem_read ? cnt + 1 : 0;
      junk <= {$urandom, $urandom, $urandom, $urandom};
   end
   assign mem_busywait = mem_read && (cnt < lat - 1);
   assign mem_readdata = (mem_read && !mem_busywait) ? mem[mem_address] : junk;

   task automatic clear_model();
      for (int i = 0; i < 8; i++) vm[i] = 0;
   endtask

   // one fetch: a miss must stall lat+2 cycles with lat request cycles; a hit must not stall
   task automatic fetch(input logic [31:0] p, input int l, input bit pre);
      int n, nr;
      bit addr_ok, miss;
      logic [2:0] idx, tg;
      logic [1:0] off;
      logic [5:0] ba;
      logic [127:0] blk;
      idx = p[6:4]; tg = p[9:7]; off = p[3:2]; ba = {tg, idx};
      miss = !(vm[idx] && tm[idx] == tg);
      if (!pre) begin
         @(posedge CLK); #1; pc = p; lat = l;
         @(negedge CLK);
      end else #1;
      n = 0; nr = 0; addr_ok = 1;
      while (busywait === 1'b1 && n < 100) begin
         if (mem_read === 1'b1) begin
            nr++;
            if (mem_address !== ba) addr_ok = 0;
         end
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n != (miss ? l + 2 : 0)) begin
         errors++;
         $display("FAIL stall_cycles pc=%h got %0d exp %0d", p, n, miss ? l + 2 : 0);
      end
      checks++;
      if (nr != (miss ? l : 0)) begin
         errors++;
         $display("FAIL read_cycles pc=%h got %0d exp %0d", p, nr, miss ? l : 0);
      end
      if (miss) begin
         checks++;
         if (!addr_ok) begin
            errors++;
            $display("FAIL mem_address pc=%h got %h exp %h", p, mem_address, ba);
         end
      end
      blk = mem[ba];
      checks++;
      if (instruction !== blk[32*off +: 32]) begin
         errors++;
         $display("FAIL instruction pc=%h got %h exp %h", p, instruction, blk[32*off +: 32]);
      end
      vm[idx] = 1; tm[idx] = tg;
   endtask

   task automatic test_reset();
      RESET = 0; pc = 0; lat = 5;
      #12;
      checks++;
      if (busywait !== 1'b1 || mem_read !== 1'b0 || instruction !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got bw=%b rd=%b ins=%h exp 1 0 0", busywait, mem_read, instruction);
      end
      clear_model();
   endtask

   task automatic test_cold_miss();
      @(negedge CLK); RESET = 1;
      fetch(32'h0, 5, 1);
   endtask

   task automatic test_seq_hits();
      fetch(32'h4, $urandom_range(1, 6), 0);
      fetch(32'h8, $urandom_range(1, 6), 0);
      fetch(32'hC, $urandom_range(1, 6), 0);
   endtask

   task automatic test_conflict();
      fetch(32'h80, 3, 0);
      fetch(32'h84, 2, 0);
      fetch(32'h0, 2, 0);
   endtask

   task automatic test_pc_change();
      logic [5:0] q[$];
      logic [5:0] exp_q[$];
      int n;
      logic [127:0] blk;
      exp_q = '{1, 1, 1, 1, 2, 2, 2, 2};
      @(posedge CLK); #1; pc = 32'h10; lat = 4;
      @(negedge CLK);
      @(negedge CLK);
      q.push_back(mem_read === 1'b1 ? mem_address : 6'h3f);
      n = 2;
      @(posedge CLK); #1; pc = 32'h20;
      @(negedge CLK);
      while (busywait === 1'b1 && n < 100) begin
         if (mem_read === 1'b1) q.push_back(mem_address);
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n != 12) begin
         errors++;
         $display("FAIL midchange_stall got %0d exp 12", n);
      end
      checks++;
      if (q != exp_q) begin
         errors++;
         $display("FAIL midchange_addrs got %0d reads first %h exp 8 reads 1 then 2", q.size(), q.size() ? q[0] : 6'h0);
      end
      blk = mem[2];
      checks++;
      if (instruction !== blk[31:0]) begin
         errors++;
         $display("FAIL midchange_ins got %h exp %h", instruction, blk[31:0]);
      end
      vm[1] = 1; tm[1] = 0; vm[2] = 1; tm[2] = 0;
      fetch(32'h14, 3, 0);
   endtask

   task automatic test_reset_mid();
      @(posedge CLK); #1; pc = 32'h50; lat = 5;
      @(negedge CLK);
      @(negedge CLK);
      #2 RESET = 0; pc = 32'h10; lat = 3;
      #1;
      checks++;
      if (mem_read !== 1'b0 || busywait !== 1'b1) begin
         errors++;
         $display("FAIL reset_midrefill got rd=%b bw=%b exp 0 1", mem_read, busywait);
      end
      clear_model();
      @(negedge CLK); RESET = 1;
      fetch(32'h10, 3, 1);
      fetch(32'h50, 2, 0);
   endtask

   task automatic test_reset_release();
      @(posedge CLK); #1; RESET = 0; pc = 32'h0; lat = 2;
      clear_model();
      @(negedge CLK); RESET = 1;
      checks++;
      if (busywait !== 1'b1) begin
         errors++;
         $display("FAIL release_busy got %b exp 1", busywait);
      end
      fetch(32'h0, 2, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) fetch($urandom, $urandom_range(1, 6), 0);
   endtask

   initial begin
      checks = 0; errors = 0;
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[0][31:0] = 32'h08040001;
      test_reset();
      test_cold_miss();
      test_seq_hits();
      test_conflict();
      test_pc_change();
      test_reset_mid();
      test_reset_release();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
